// File: rtl/regfile_bypass_sb.sv
// Parametrised integer register file with write-to-read bypass, a per-register
// pending scoreboard, and a sequential clear engine that zeroes the array after reset.
module regfile_bypass_sb #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  input  logic            set_en,
  input  logic [AW-1:0]   set_addr,
  output logic            pend1,
  output logic            pend2,
  output logic            ready
);

  localparam int NREGS = 1 << AW;
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state, state_nxt;
  logic [AW-1:0]     clr_idx, clr_idx_nxt;
  logic [XLEN-1:0]   regs [NREGS];
  logic [NREGS-1:0]  pend;
  logic              wr_en;
  logic              set_ok;

  // Stored value is overridden by zero (entry 0 / not ready) or by the in-flight write.
  function automatic logic [XLEN-1:0] read_sel(
    input logic            rdy,
    input logic [AW-1:0]   ra,
    input logic            w_en,
    input logic [AW-1:0]   w_addr,
    input logic [XLEN-1:0] w_data,
    input logic [XLEN-1:0] stored
  );
    if (!rdy || ra == '0) return '0;
    if (w_en && w_addr == ra) return w_data;
    return stored;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    case (state)
      CLEAR: begin
        clr_idx_nxt = clr_idx + AW'(1);
        if (clr_idx == LAST_IDX) state_nxt = RUN;
      end
      RUN: begin
        state_nxt = RUN;
      end
      default: state_nxt = CLEAR;
    endcase
  end

  assign ready  = (state == RUN);
  assign wr_en  = ready && we && (wa != '0);
  assign set_ok = ready && set_en && (set_addr != '0);

  // Data array carries no reset; the clear engine owns it while in CLEAR.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      regs[clr_idx] <= '0;
    end else if (wr_en) begin
      regs[wa] <= wd;
    end
  end

  // A set landing on the same entry as a writeback wins: the new producer is still outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
    end else begin
      if (wr_en)  pend[wa]       <= 1'b0;
      if (set_ok) pend[set_addr] <= 1'b1;
    end
  end

  assign rd1 = read_sel(ready, ra1, we, wa, wd, regs[ra1]);
  assign rd2 = read_sel(ready, ra2, we, wa, wd, regs[ra2]);

  assign pend1 = ready & pend[ra1] & ~(we & (wa == ra1));
  assign pend2 = ready & pend[ra2] & ~(we & (wa == ra2));

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Scoreboard bench for regfile_bypass_sb: a behavioural model pushes expected
// outputs each cycle, which are popped and compared against the live DUT outputs.
module tb_regfile_bypass_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ra1, ra2, wa, set_addr;
  logic [31:0] rd1, rd2, wd;
  logic        we, set_en, pend1, pend2, ready;

  regfile_bypass_sb #(.XLEN(32), .AW(5)) dut (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .we(we), .wa(wa), .wd(wd), .set_en(set_en), .set_addr(set_addr),
    .pend1(pend1), .pend2(pend2), .ready(ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        p1;
    logic        p2;
    logic        rdy;
  } obs_t;

  obs_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          mv = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_pend;
  bit          m_run;
  int          m_idx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_rd(input logic [4:0] ra);
    if (!m_run || ra == 5'd0) return 32'd0;
    if (we && wa == ra) return wd;
    return m_regs[ra];
  endfunction

  function automatic logic m_pd(input logic [4:0] ra);
    return m_run && m_pend[ra] && !(we && wa == ra);
  endfunction

  function automatic obs_t model_out();
    obs_t e;
    e.rd1 = m_rd(ra1);
    e.rd2 = m_rd(ra2);
    e.p1  = m_pd(ra1);
    e.p2  = m_pd(ra2);
    e.rdy = m_run;
    return e;
  endfunction

  task automatic model_update();
    if (rst) begin
      m_run  = 0;
      m_idx  = 0;
      m_pend = 32'd0;
    end else if (!m_run) begin
      m_regs[m_idx] = 32'd0;
      if (m_idx == 31) m_run = 1;
      m_idx = (m_idx + 1) % 32;
    end else begin
      if (we && wa != 5'd0) begin
        m_regs[wa] = wd;
        m_pend[wa] = 1'b0;
      end
      if (set_en && set_addr != 5'd0) m_pend[set_addr] = 1'b1;
    end
  endtask

  // Called mid-low-phase with inputs stable; checks, then advances one edge.
  task automatic tick(input string tag);
    obs_t e;
    if (mv) begin
      exp_q.push_back(model_out());
      e = exp_q.pop_front();
      chk({tag, "_rd1"},   rd1, e.rd1);
      chk({tag, "_rd2"},   rd2, e.rd2);
      chk({tag, "_pend1"}, {31'd0, pend1}, {31'd0, e.p1});
      chk({tag, "_pend2"}, {31'd0, pend2}, {31'd0, e.p2});
      chk({tag, "_ready"}, {31'd0, ready}, {31'd0, e.rdy});
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    we = 0; wa = 0; wd = 0; set_en = 0; set_addr = 0; ra1 = 0; ra2 = 0;
  endtask

  task automatic rand_inputs();
    we       = 1'($urandom_range(1, 0));
    wa       = 5'($urandom_range(31, 0));
    wd       = $urandom;
    set_en   = 1'($urandom_range(1, 0));
    set_addr = 5'($urandom_range(31, 0));
    ra1      = 5'($urandom_range(31, 0));
    ra2      = 5'($urandom_range(31, 0));
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!ready && n < 100) begin
      rand_inputs();
      #1;
      tick(tag);
      n++;
    end
    chk({tag, "_latency"}, n, 32);
    idle();
  endtask

  task automatic read_all_zero(input string tag);
    for (int a = 0; a < 32; a += 2) begin
      ra1 = 5'(a);
      ra2 = 5'(a + 1);
      #1;
      chk({tag, "_z1"}, rd1, 32'd0);
      chk({tag, "_z2"}, rd2, 32'd0);
      tick(tag);
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_pend = 32'd0; m_run = 0; m_idx = 0;
    idle();
    rst = 1;
    @(negedge clk);
    tick("rst0");
    mv = 1;

    // Reset values
    #1;
    chk("rstval_ready", {31'd0, ready}, 32'd0);
    chk("rstval_rd1", rd1, 32'd0);
    chk("rstval_pend1", {31'd0, pend1}, 32'd0);
    tick("rst1");
    rst = 0;
    wait_ready("clr1");
    read_all_zero("rd0");

    // Garbage, then reset and full clear must wipe it
    for (int a = 1; a < 32; a++) begin
      we = 1; wa = 5'(a); wd = 32'hA000_0000 | 32'(a);
      set_en = 1; set_addr = 5'(32 - a);
      #1;
      tick("garb");
    end
    idle();
    rst = 1; #1; tick("rst2");
    rst = 0;
    wait_ready("clr2");
    read_all_zero("wipe");

    // Same-cycle bypass then stored value
    we = 1; wa = 5'd5; wd = 32'hDEADBEEF; ra1 = 5'd5;
    #1; chk("byp5", rd1, 32'hDEADBEEF); tick("byp5");
    we = 0;
    #1; chk("hold5", rd1, 32'hDEADBEEF); tick("hold5");

    // Entry 0 is hardwired zero, never pending
    we = 1; wa = 5'd0; wd = 32'hFFFFFFFF; ra1 = 0; ra2 = 0; set_en = 1; set_addr = 0;
    #1; chk("r0_rd1", rd1, 32'd0); chk("r0_rd2", rd2, 32'd0); tick("r0a");
    we = 0; set_en = 0;
    #1; chk("r0_next", rd1, 32'd0); chk("r0_pend", {31'd0, pend1}, 32'd0); tick("r0b");

    // Scoreboard set, then writeback clears it
    set_en = 1; set_addr = 5'd7; ra1 = 5'd7;
    #1; chk("set7_same", {31'd0, pend1}, 32'd0); tick("set7");
    set_en = 0;
    #1; chk("set7_pend", {31'd0, pend1}, 32'd1); tick("set7b");
    we = 1; wa = 5'd7; wd = 32'h1234_5678;
    #1; chk("wb7_pend", {31'd0, pend1}, 32'd0); chk("wb7_rd", rd1, 32'h1234_5678); tick("wb7");
    we = 0;
    #1; chk("wb7_after", {31'd0, pend1}, 32'd0); tick("wb7c");

    // Set and write to the same entry: set wins, data lands
    we = 1; wa = 5'd9; wd = 32'hA5A5_5A5A; set_en = 1; set_addr = 5'd9; ra2 = 5'd9;
    #1; tick("sw9");
    idle(); ra2 = 5'd9;
    #1; chk("sw9_pend", {31'd0, pend2}, 32'd1); chk("sw9_rd", rd2, 32'hA5A5_5A5A); tick("sw9b");
    idle();

    // Reset in the middle of the clear restarts it
    rst = 1; #1; tick("rst3");
    rst = 0;
    for (int c = 0; c < 10; c++) begin
      rand_inputs(); #1; tick("midclr");
    end
    idle();
    rst = 1; #1; tick("rst4");
    rst = 0;
    wait_ready("clr3");
    read_all_zero("midz");

    // Random traffic on a narrow address range to provoke hazards
    for (int c = 0; c < 400; c++) begin
      rand_inputs();
      wa = wa & 5'h0F; set_addr = set_addr & 5'h0F; ra1 = ra1 & 5'h0F; ra2 = ra2 & 5'h0F;
      #1;
      tick("rnd");
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_bypass_sb.md
# regfile_bypass_sb

Parametrised integer register file for the pipelined RISC-V core. It replaces the fixed 32x32 two-read/one-write file with configurable width and depth, and adds a same-cycle write-to-read bypass. It also provides a per-register pending scoreboard for hazard detection in decode and a sequential clear engine that zeroes the whole array after reset. It sits between the decode stage (reads, scoreboard set) and the writeback stage (write, scoreboard clear).

## Interface
- XLEN, 32, data width in bits
- AW, 5, address width; NREGS = 2**AW entries; entry 0 is hardwired zero
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ra1  in  AW  read address, port 1
- ra2  in  AW  read address, port 2
- rd1  out  XLEN  read data, port 1 (combinational)
- rd2  out  XLEN  read data, port 2 (combinational)
- we  in  1  write enable (writeback)
- wa  in  AW  write address
- wd  in  XLEN  write data
- set_en  in  1  mark register set_addr as pending (decode issues a producer)
- set_addr  in  AW  register to mark pending
- pend1  out  1  ra1 has an outstanding producer not yet written back
- pend2  out  1  ra2 has an outstanding producer not yet written back
- ready  out  1  clear sequence complete; file usable

## Operation
- FSM states: CLEAR, RUN. rst=1 -> state CLEAR, clr_idx=0, ready=0, all pending bits=0. Reset takes effect identically mid-clear and mid-run.
- CLEAR: each clock with rst=0, write 0 to entry clr_idx, then clr_idx += 1. After entry NREGS-1 is cleared, go to RUN and set ready=1. clr_idx is AW bits wide; the terminal compare is on NREGS-1, not on wrap.
- In CLEAR, we and set_en are ignored, rd1/rd2 = 0, and pend1/pend2 = 0.
- RUN write: if we=1 and wa!=0, then reg[wa] <= wd and pend[wa] <= 0. Writes to entry 0 are dropped and reg[0] stays 0.
- RUN set: if set_en=1 and set_addr!=0, then pend[set_addr] <= 1. set_addr=0 is ignored and pend[0] is always 0.
- Simultaneous set and write to the same address: the write updates data, and pend ends at 1 (set wins, because the new producer supersedes the old one).
- Read, per port n: if ran=0, rdn=0. Otherwise, if we=1 and wa=ran and ready=1, rdn=wd (bypass). Otherwise rdn=reg[ran]. Both ports may read the same address.
- Pending output: pendn = ready & pend[ran] & ~(we & wa==ran). A register being written back this cycle reports not pending, which matches the bypassed data. A set_en in the same cycle does not affect pendn until the next cycle.
- Registers never written since the clear read 0.

## Timing
- Reset values: ready=0, rd1=rd2=0, pend1=pend2=0, all pending bits=0, state=CLEAR.
- Clear latency: ready rises after exactly NREGS rising edges with rst=0 (32 for AW=5).
- Write latency: data is in the array from the next edge and on rd the same cycle through the bypass.
- Scoreboard latency: a set is visible on pendn from the next cycle. A clear is visible the same cycle through the bypass term and held from the next edge.
- Reads are asynchronous, with no read latency or handshake.
- Reset asserted mid-clear restarts clr_idx at 0. Reset in RUN drops ready next edge and repeats the full clear.

## Test plan
- Reset for 1 cycle, then release -> ready=0 for 32 cycles and 1 on cycle 32. Reading every address after that returns 0. Pre-load garbage via writes before reset and confirm it is gone.
- In RUN, we=1, wa=5, wd=0xDEADBEEF, ra1=5 the same cycle -> rd1=0xDEADBEEF that cycle. Next cycle with we=0 -> rd1=0xDEADBEEF.
- Write wa=0, wd=0xFFFFFFFF, ra1=ra2=0 -> rd1=rd2=0 that cycle and the next. Also set_en on address 0 -> pend stays 0.
- set_en, set_addr=7; next cycle ra1=7 -> pend1=1. Later we, wa=7 -> pend1=0 that cycle and rd1=wd. The following cycle -> pend1=0.
- Same cycle we, wa=9 and set_en, set_addr=9 -> next cycle pend(9)=1 and reg[9] holds the written data.
- Assert rst at clear cycle 10, then release -> ready rises 32 cycles after the release, not 22. Writes issued during CLEAR are not retained.
